// File: rtl/keccak_pad_pkg.sv
// keccak_pad_pkg
// Shared constants and state encoding for the Keccak stream padder.
//   SUFFIX_*  : domain-separation bytes placed right after the message
//   PAD_FINAL : the closing '1' bit of pad10*1, in the last byte of a block
//   RATE_*    : block widths in bits for the common SHA3/SHAKE modes
//   pad_state_t : padder FSM states
package keccak_pad_pkg;

    localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
    localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_FINAL    = 8'h80;

    localparam int RATE_SHA3_256 = 1088;
    localparam int RATE_SHA3_512 = 576;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    typedef enum logic [1:0] {
        ACCUM,
        PAD,
        FULL
    } pad_state_t;

endpackage

// File: rtl/keccak_pad_word.sv
// keccak_pad_word
// Combinational masking of the final message word.
// Ports:
//   data    : message word, first byte in the MSBs
//   n_bytes : number of valid leading bytes (0..IN_BYTES)
//   suffix  : domain byte written right after the last valid byte
//   padded  : valid bytes kept, suffix inserted, remaining bytes zero
module keccak_pad_word
    import keccak_pad_pkg::*;
#(
    parameter int IN_BYTES = 8
) (
    input  logic [IN_BYTES*8-1:0]          data,
    input  logic [$clog2(IN_BYTES+1)-1:0]  n_bytes,
    input  logic [7:0]                     suffix,
    output logic [IN_BYTES*8-1:0]          padded
);

    // Byte j counts from the MSB end; a full word (n_bytes==IN_BYTES)
    // never matches the suffix position, so it passes through untouched.
    always_comb begin
        padded = '0;
        for (int j = 0; j < IN_BYTES; j++) begin
            if (j < int'(n_bytes)) begin
                padded[(IN_BYTES-1-j)*8 +: 8] = data[(IN_BYTES-1-j)*8 +: 8];
            end else if (j == int'(n_bytes)) begin
                padded[(IN_BYTES-1-j)*8 +: 8] = suffix;
            end
        end
    end

endmodule

// File: rtl/keccak_stream_padder.sv
// keccak_stream_padder
// Streams message words into RATE_BITS-wide Keccak blocks, applies the
// domain suffix and the final 0x80 bit, and hands blocks to the permutation.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   in/in_valid/in_ready/in_last/in_bytes : message word stream
//   suffix            : domain byte, captured with the last word
//   out/out_valid/out_ack/last_block      : padded block handshake
//   msg_bytes         : accepted message byte count (KECCAK_PAD_BYTE_COUNT_EN)
// Optional feature macro: KECCAK_PAD_BYTE_COUNT_EN
module keccak_stream_padder
    import keccak_pad_pkg::*;
#(
    parameter int RATE_BITS = 576,
    parameter int IN_BYTES  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_BYTES*8-1:0]         in,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [$clog2(IN_BYTES+1)-1:0] in_bytes,
    input  logic [7:0]                    suffix,
    output logic                          in_ready,
    output logic [RATE_BITS-1:0]          out,
    output logic                          out_valid,
    output logic                          last_block,
    input  logic                          out_ack
`ifdef KECCAK_PAD_BYTE_COUNT_EN
    ,
    output logic [63:0]                   msg_bytes
`endif
);

    localparam int WB = IN_BYTES * 8;
    localparam int W  = RATE_BITS / WB;
    localparam int CW = $clog2(W + 1);
    localparam int BW = $clog2(IN_BYTES + 1);

    pad_state_t     state, next_state;
    logic [CW-1:0]  count, count_nx, count_inc;
    logic           pad_pending, pend_nx;
    logic           msg_done, done_nx;
    logic [7:0]     suffix_q;
    logic           shift_en;
    logic [WB-1:0]  new_word;
    logic [WB-1:0]  last_word;

    keccak_pad_word #(
        .IN_BYTES (IN_BYTES)
    ) u_pad_word (
        .data    (in),
        .n_bytes (in_bytes),
        .suffix  (suffix),
        .padded  (last_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Next state, handshake outputs and the word to shift in this cycle.
    // The final 0x80 goes into whichever word completes the block of a
    // finished message, judged on the flags as they will be after this word.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        new_word   = '0;
        done_nx    = msg_done;
        pend_nx    = pad_pending;
        count_inc  = count + 1'b1;
        count_nx   = count;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        last_block = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_en = 1'b1;
                    count_nx = count_inc;
                    if (in_last) begin
                        new_word = last_word;
                        done_nx  = 1'b1;
                        if (in_bytes == BW'(IN_BYTES)) begin
                            pend_nx = 1'b1;
                        end
                        next_state = (count_inc < CW'(W)) ? PAD : FULL;
                    end else begin
                        new_word = in;
                        if (count_inc == CW'(W)) begin
                            next_state = FULL;
                        end
                    end
                end
            end
            PAD: begin
                shift_en = 1'b1;
                count_nx = count_inc;
                new_word = pad_pending ? (WB'(suffix_q) << (WB - 8)) : '0;
                pend_nx  = 1'b0;
                if (count_inc == CW'(W)) begin
                    next_state = FULL;
                end
            end
            FULL: begin
                out_valid  = 1'b1;
                last_block = msg_done && !pad_pending;
                if (out_ack) begin
                    count_nx = '0;
                    if (msg_done && !pad_pending) begin
                        done_nx    = 1'b0;
                        next_state = ACCUM;
                    end else if (msg_done && pad_pending) begin
                        next_state = PAD;
                    end else begin
                        next_state = ACCUM;
                    end
                end
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
        if (shift_en && count_nx == CW'(W) && done_nx && !pend_nx) begin
            new_word[7:0] = new_word[7:0] | PAD_FINAL;
        end
    end

    // Block buffer and message bookkeeping; words enter at the LSBs so the
    // first word of a block ends up in the MSBs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out         <= '0;
            count       <= '0;
            pad_pending <= 1'b0;
            msg_done    <= 1'b0;
            suffix_q    <= '0;
        end else begin
            if (shift_en) begin
                out <= (out << WB) | RATE_BITS'(new_word);
            end
            if (in_ready && in_valid && in_last) begin
                suffix_q <= suffix;
            end
            count       <= count_nx;
            pad_pending <= pend_nx;
            msg_done    <= done_nx;
        end
    end

`ifdef KECCAK_PAD_BYTE_COUNT_EN
    logic restart;

    // Count restarts on the first word after a last word, so the total of
    // the previous message stays visible until then.
    always_ff @(posedge clk) begin
        if (!reset) begin
            msg_bytes <= '0;
            restart   <= 1'b0;
        end else if (in_ready && in_valid) begin
            msg_bytes <= (restart ? 64'd0 : msg_bytes) +
                         (in_last ? 64'(in_bytes) : 64'(IN_BYTES));
            restart   <= in_last;
        end
    end
`else
    // Byte counter absent in this build.
`endif

endmodule

// File: tb/tb_keccak_stream_padder.sv
// tb_keccak_stream_padder
// Directed bench for keccak_stream_padder at RATE_BITS=576, IN_BYTES=8.
module tb_keccak_stream_padder;
    import keccak_pad_pkg::*;

    localparam int RATE = 576;
    localparam int IB   = 8;

    logic            clk;
    logic            reset;
    logic [IB*8-1:0] in;
    logic            in_valid;
    logic            in_last;
    logic [3:0]      in_bytes;
    logic [7:0]      suffix;
    logic            in_ready;
    logic [RATE-1:0] out;
    logic            out_valid;
    logic            last_block;
    logic            out_ack;
`ifdef KECCAK_PAD_BYTE_COUNT_EN
    logic [63:0]     msg_bytes;
`endif

    int compared;
    int mismatched;
    int cycles;
    logic [RATE-1:0] exp_blk;
    logic [RATE-1:0] held;
    logic [63:0]     w;

    keccak_stream_padder #(
        .RATE_BITS (RATE),
        .IN_BYTES  (IB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .suffix     (suffix),
        .in_ready   (in_ready),
        .out        (out),
        .out_valid  (out_valid),
        .last_block (last_block),
        .out_ack    (out_ack)
`ifdef KECCAK_PAD_BYTE_COUNT_EN
        ,
        .msg_bytes  (msg_bytes)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [RATE-1:0] obs,
                               input logic [RATE-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Present one word for exactly one clock edge.
    task automatic applyStimulus(input logic [63:0] data, input logic last,
                                 input logic [3:0] nb, input logic [7:0] suf);
        in       = data;
        in_last  = last;
        in_bytes = nb;
        suffix   = suf;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic ackBlock();
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        in         = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_bytes   = '0;
        suffix     = '0;
        out_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", RATE'(in_ready), RATE'(1));
        checkOutput("rst_out_valid", RATE'(out_valid), RATE'(0));
        checkOutput("rst_last_block", RATE'(last_block), RATE'(0));
        checkOutput("rst_out", out, '0);
        reset = 1'b1;

        $display("[TB] single partial word");
        applyStimulus(64'h90ABCDEF11111111, 1'b1, 4'd3, SUFFIX_SHA3);
        waitValid(cycles);
        checkOutput("t1_pad_cycles", RATE'(cycles), RATE'(8));
        checkOutput("t1_block", out, {64'h90ABCD0600000000, 504'b0, 8'h80});
        checkOutput("t1_last_block", RATE'(last_block), RATE'(1));
        ackBlock();

        $display("[TB] suffix and final bit share the last byte");
        exp_blk = '0;
        out_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 64'h1111111111111111 * 64'(i + 1);
            applyStimulus(w, 1'b0, 4'd8, SUFFIX_SHA3);
            exp_blk = (exp_blk << 64) | RATE'(w);
            if (i == 3) out_ack = 1'b0;
        end
        applyStimulus(64'hA1A2A3A4A5A6A7A8, 1'b1, 4'd7, SUFFIX_SHA3);
        exp_blk = (exp_blk << 64) | RATE'(64'hA1A2A3A4A5A6A786);
        waitValid(cycles);
        checkOutput("t2_pad_cycles", RATE'(cycles), RATE'(0));
        checkOutput("t2_block", out, exp_blk);
        checkOutput("t2_last_byte", RATE'(out[7:0]), RATE'(8'h86));
        checkOutput("t2_last_block", RATE'(last_block), RATE'(1));
`ifdef KECCAK_PAD_BYTE_COUNT_EN
        checkOutput("t2_msg_bytes", RATE'(msg_bytes), RATE'(71));
`endif
        ackBlock();

        $display("[TB] message ends on block boundary");
        exp_blk = '0;
        for (int i = 0; i < 9; i++) begin
            w = {8{8'(8'h10 + i)}};
            applyStimulus(w, (i == 8), 4'd8, SUFFIX_SHA3);
            exp_blk = (exp_blk << 64) | RATE'(w);
        end
        waitValid(cycles);
        checkOutput("t3_b1_cycles", RATE'(cycles), RATE'(0));
        checkOutput("t3_b1_block", out, exp_blk);
        checkOutput("t3_b1_last_block", RATE'(last_block), RATE'(0));
        ackBlock();
        waitValid(cycles);
        checkOutput("t3_b2_cycles", RATE'(cycles), RATE'(9));
        checkOutput("t3_b2_block", out, {8'h06, 560'b0, 8'h80});
        checkOutput("t3_b2_last_block", RATE'(last_block), RATE'(1));
        ackBlock();

        $display("[TB] empty SHAKE message");
        applyStimulus(64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd0, SUFFIX_SHAKE);
        waitValid(cycles);
        checkOutput("t4_pad_cycles", RATE'(cycles), RATE'(8));
        checkOutput("t4_block", out, {8'h1F, 560'b0, 8'h80});

        $display("[TB] back-pressure on the output");
        held     = out;
        in       = 64'hDEADBEEFCAFEF00D;
        in_last  = 1'b1;
        in_bytes = 4'd3;
        suffix   = SUFFIX_SHA3;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t5_out_held", out, held);
        checkOutput("t5_in_ready_low", RATE'(in_ready), RATE'(0));
        checkOutput("t5_out_valid_high", RATE'(out_valid), RATE'(1));
        ackBlock();
        checkOutput("t5_ready_after_ack", RATE'(in_ready), RATE'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("t5_word_taken", RATE'(in_ready), RATE'(0));
        waitValid(cycles);
        checkOutput("t5_pad_cycles", RATE'(cycles), RATE'(8));
        checkOutput("t5_block", out, {64'hDEADBE0600000000, 504'b0, 8'h80});
        ackBlock();

        $display("[TB] reset mid-block");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(64'h5555AAAA5555AAAA, 1'b0, 4'd8, SUFFIX_SHA3);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("t6_in_ready", RATE'(in_ready), RATE'(1));
        checkOutput("t6_out_valid", RATE'(out_valid), RATE'(0));
        checkOutput("t6_out", out, '0);
        applyStimulus(64'h90ABCDEF11111111, 1'b1, 4'd3, SUFFIX_SHA3);
        waitValid(cycles);
        checkOutput("t6_pad_cycles", RATE'(cycles), RATE'(8));
        checkOutput("t6_block", out, {64'h90ABCD0600000000, 504'b0, 8'h80});

        $display("[TB] reset while a block is presented");
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("t7_out_valid", RATE'(out_valid), RATE'(0));
        checkOutput("t7_last_block", RATE'(last_block), RATE'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
